mem_ctrl_sp: RTL and testbench

- Parametrised single-port memory with a registered valid/ready request interface and a 1-cycle read response.
- Replaces the earlier fixed 64x4, level-sensitive enable/rd_wr store.
- On reset exit, a hardware init sweep writes INIT_VAL to every word; no request is accepted until the sweep is done.
- Sits between the exercise datapaths and their storage, so every client sees a known memory state.

---
 rtl/mem_ctrl_pkg.sv | 17 +
 rtl/mem_array_sp.sv | 48 ++++
 rtl/mem_ctrl_sp.sv | 128 ++++++++++++
 tb/tb_mem_ctrl_sp.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the single-port memory controller.
package mem_ctrl_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int DATA_W_DEF = 4;
    localparam int ADDR_W_DEF = 6;

    // One extra bit so a sweep over a full 2**ADDR_W array still terminates.
    function automatic int cnt_width(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/mem_array_sp.sv
// DEPTH x DATA_W storage with a synchronous write port and a registered read port.
// Optional asynchronous probe read port when MEM_CTRL_PROBE_EN is defined.
module mem_array_sp
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
`ifdef MEM_CTRL_PROBE_EN
    input  logic [ADDR_W-1:0] probe_addr,
    output logic [DATA_W-1:0] probe_data,
`endif
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage itself is never reset; the controller's init sweep defines it.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

`ifdef MEM_CTRL_PROBE_EN
    localparam int CNT_W = cnt_width(ADDR_W);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    assign probe_data = ({1'b0, probe_addr} < DEPTH_C) ? mem[probe_addr] : '0;
`endif

endmodule

// File: rtl/mem_ctrl_sp.sv
// Single-port memory controller: init sweep to INIT_VAL after reset, then valid/ready
// requests with a one-cycle read response. MEM_CTRL_PROBE_EN adds a debug probe port.
module mem_ctrl_sp
    import mem_ctrl_pkg::*;
#(
    parameter int                DATA_W   = DATA_W_DEF,
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DEPTH    = 64,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              wr_err,
`ifdef MEM_CTRL_PROBE_EN
    input  logic [ADDR_W-1:0] probe_addr,
    output logic [DATA_W-1:0] probe_data,
`endif
    output logic              init_done
);

    localparam int CNT_W = cnt_width(ADDR_W);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(DEPTH - 1);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               accept;
    logic               in_range;
    logic               rd_zero_q;
    logic               mem_we;
    logic               mem_re;
    logic [ADDR_W-1:0]  mem_waddr;
    logic [DATA_W-1:0]  mem_wdata;
    logic [DATA_W-1:0]  arr_rdata;

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_ready is registered, depends only on the FSM state and never on req_valid,
    // and there is no response backpressure (rsp_valid is a one-cycle pulse).
    assign accept   = req_valid & req_ready;
    assign in_range = {1'b0, req_addr} < DEPTH_C;

    always_comb begin
        state_d   = state_q;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_waddr = req_addr;
        mem_wdata = req_wdata;
        case (state_q)
            ST_INIT: begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q[ADDR_W-1:0];
                mem_wdata = INIT_VAL;
                if (cnt_q == LAST_C) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                mem_we = accept & req_wr & in_range;
                mem_re = accept & ~req_wr & in_range;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_INIT;
            cnt_q     <= '0;
            req_ready <= 1'b0;
            init_done <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_ready <= (state_d == ST_RUN);
            init_done <= (state_d == ST_RUN);
            if (state_q == ST_INIT) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // rd_zero_q remembers whether the latest read was out of range so the
    // held rsp_rdata stays 0 until the next read replaces it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            wr_err    <= 1'b0;
            rd_zero_q <= 1'b0;
        end else begin
            rsp_valid <= accept & ~req_wr;
            rsp_err   <= accept & ~req_wr & ~in_range;
            wr_err    <= accept & req_wr & ~in_range;
            if (accept & ~req_wr) begin
                rd_zero_q <= ~in_range;
            end
        end
    end

    assign rsp_rdata = rd_zero_q ? '0 : arr_rdata;

    mem_array_sp #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk        (clk),
        .rst_n      (rst_n),
        .we         (mem_we),
        .waddr      (mem_waddr),
        .wdata      (mem_wdata),
        .re         (mem_re),
        .raddr      (req_addr),
`ifdef MEM_CTRL_PROBE_EN
        .probe_addr (probe_addr),
        .probe_data (probe_data),
`endif
        .rdata      (arr_rdata)
    );

endmodule

// File: tb/tb_mem_ctrl_sp.sv
// Bench for mem_ctrl_sp: instance 0 uses defaults, instance 1 uses DEPTH=48, INIT_VAL=4'hA.
module tb_mem_ctrl_sp;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid [2];
    logic       req_wr    [2];
    logic [5:0] req_addr  [2];
    logic [3:0] req_wdata [2];
    logic       req_ready [2];
    logic       rsp_valid [2];
    logic [3:0] rsp_rdata [2];
    logic       rsp_err   [2];
    logic       wr_err    [2];
    logic       init_done [2];
`ifdef MEM_CTRL_PROBE_EN
    logic [5:0] probe_addr [2];
    logic [3:0] probe_data [2];
`endif

    int errors = 0;
    int checks = 0;
    logic [4:0] exp_q0 [$];
    logic [4:0] exp_q1 [$];
    logic [3:0] m0 [64];

    typedef struct {
        int         inst;
        logic       wr;
        logic [5:0] addr;
        logic [3:0] data;
        logic [4:0] exp_rsp;
        logic       exp_wr_err;
    } vec_t;

    vec_t vecs [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_ctrl_sp #(
            .DATA_W   (4),
            .ADDR_W   (6),
            .DEPTH    (g == 0 ? 64 : 48),
            .INIT_VAL (g == 0 ? 4'h0 : 4'hA)
        ) dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_wr     (req_wr[g]),
            .req_addr   (req_addr[g]),
            .req_wdata  (req_wdata[g]),
            .rsp_valid  (rsp_valid[g]),
            .rsp_rdata  (rsp_rdata[g]),
            .rsp_err    (rsp_err[g]),
            .wr_err     (wr_err[g]),
`ifdef MEM_CTRL_PROBE_EN
            .probe_addr (probe_addr[g]),
            .probe_data (probe_data[g]),
`endif
            .init_done  (init_done[g])
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int inst, input logic wr, input logic [5:0] addr,
                                input logic [3:0] data, input logic [4:0] exp_rsp,
                                input logic exp_wr_err);
        vec_t v;
        v.inst = inst; v.wr = wr; v.addr = addr; v.data = data;
        v.exp_rsp = exp_rsp; v.exp_wr_err = exp_wr_err;
        return v;
    endfunction

    // Scoreboard: every rsp_valid pops the oldest expected {err, data}.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                if (rsp_valid[i]) begin
                    logic [4:0] e;
                    int n;
                    e = '0;
                    n = (i == 0) ? exp_q0.size() : exp_q1.size();
                    if (n > 0) e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                    if (n == 0) chk($sformatf("rsp_unexpected[%0d]", i), 32'(1), 32'(0));
                    else chk($sformatf("rsp_err_data[%0d]", i), 32'({rsp_err[i], rsp_rdata[i]}), 32'(e));
                end
            end
        end
    end

    // Called at a falling edge; returns at the next falling edge after acceptance.
    task automatic drive(input int i, input logic wr, input logic [5:0] addr, input logic [3:0] data,
                         input logic [4:0] exp_rsp, input logic exp_wr_err);
        req_valid[i]   = 1'b1;
        req_valid[1-i] = 1'b0;
        req_wr[i]      = wr;
        req_addr[i]    = addr;
        req_wdata[i]   = data;
        if (!wr) begin
            if (i == 0) exp_q0.push_back(exp_rsp);
            else        exp_q1.push_back(exp_rsp);
        end
        @(negedge clk);
        chk($sformatf("wr_err[%0d]", i), 32'(wr_err[i]), 32'(exp_wr_err));
    endtask

    task automatic idle(input int n);
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_ready[%0d]", tag, i), 32'(req_ready[i]), 32'(0));
            chk($sformatf("%s_rsp_valid[%0d]", tag, i), 32'(rsp_valid[i]), 32'(0));
            chk($sformatf("%s_rdata[%0d]", tag, i), 32'(rsp_rdata[i]), 32'(0));
            chk($sformatf("%s_rsp_err[%0d]", tag, i), 32'(rsp_err[i]), 32'(0));
            chk($sformatf("%s_wr_err[%0d]", tag, i), 32'(wr_err[i]), 32'(0));
            chk($sformatf("%s_init_done[%0d]", tag, i), 32'(init_done[i]), 32'(0));
        end
    endtask

    // Counts cycles after release; instance 0 must open at 64, instance 1 at 48.
    task automatic sweep_check(input string tag);
        for (int c = 1; c <= 64; c++) begin
            @(negedge clk);
            chk($sformatf("%s_ready0_c%0d", tag, c), 32'(req_ready[0]), 32'(c == 64));
            chk($sformatf("%s_done0_c%0d", tag, c), 32'(init_done[0]), 32'(c == 64));
            chk($sformatf("%s_ready1_c%0d", tag, c), 32'(req_ready[1]), 32'(c >= 48));
            chk($sformatf("%s_done1_c%0d", tag, c), 32'(init_done[1]), 32'(c >= 48));
            if (c == 48) req_valid[1] = 1'b0;
            if (c == 64) req_valid[0] = 1'b0;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0; req_wr[i] = 1'b0; req_addr[i] = '0; req_wdata[i] = '0;
`ifdef MEM_CTRL_PROBE_EN
            probe_addr[i] = '0;
`endif
        end
        #23;
        check_reset_outputs("rst");

        // Requests held during the sweep must be ignored.
        @(negedge clk);
        req_valid[0] = 1'b1; req_wr[0] = 1'b1; req_addr[0] = 6'd0; req_wdata[0] = 4'hF;
        req_valid[1] = 1'b1; req_wr[1] = 1'b1; req_addr[1] = 6'd0; req_wdata[1] = 4'h3;
        rst_n = 1'b1;
        sweep_check("init");

        for (int a = 0; a < 64; a++) drive(0, 1'b0, 6'(a), 4'h0, 5'h00, 1'b0);
        for (int a = 0; a < 48; a++) drive(1, 1'b0, 6'(a), 4'h0, 5'h0A, 1'b0);
        idle(2);

        vecs.push_back(mk(1, 1'b1, 6'd7,  4'h3, 5'h00, 1'b0));
        vecs.push_back(mk(1, 1'b0, 6'd7,  4'h0, 5'h03, 1'b0));
        vecs.push_back(mk(1, 1'b0, 6'd0,  4'h0, 5'h0A, 1'b0));
        vecs.push_back(mk(1, 1'b1, 6'd0,  4'h1, 5'h00, 1'b0));
        vecs.push_back(mk(1, 1'b1, 6'd1,  4'h2, 5'h00, 1'b0));
        vecs.push_back(mk(1, 1'b0, 6'd0,  4'h0, 5'h01, 1'b0));
        vecs.push_back(mk(1, 1'b0, 6'd1,  4'h0, 5'h02, 1'b0));
        vecs.push_back(mk(1, 1'b1, 6'd50, 4'hF, 5'h00, 1'b1));
        vecs.push_back(mk(1, 1'b0, 6'd50, 4'h0, 5'h10, 1'b0));
        vecs.push_back(mk(1, 1'b0, 6'd2,  4'h0, 5'h0A, 1'b0));
        vecs.push_back(mk(1, 1'b0, 6'd18, 4'h0, 5'h0A, 1'b0));
        vecs.push_back(mk(1, 1'b0, 6'd47, 4'h0, 5'h0A, 1'b0));
        vecs.push_back(mk(1, 1'b1, 6'd47, 4'h6, 5'h00, 1'b0));
        vecs.push_back(mk(1, 1'b0, 6'd47, 4'h0, 5'h06, 1'b0));
        vecs.push_back(mk(1, 1'b0, 6'd48, 4'h0, 5'h10, 1'b0));
        vecs.push_back(mk(1, 1'b1, 6'd48, 4'h5, 5'h00, 1'b1));
        vecs.push_back(mk(1, 1'b0, 6'd63, 4'h0, 5'h10, 1'b0));
        vecs.push_back(mk(0, 1'b1, 6'd63, 4'hC, 5'h00, 1'b0));
        vecs.push_back(mk(0, 1'b0, 6'd63, 4'h0, 5'h0C, 1'b0));
        vecs.push_back(mk(0, 1'b1, 6'd0,  4'h1, 5'h00, 1'b0));
        vecs.push_back(mk(0, 1'b1, 6'd1,  4'h2, 5'h00, 1'b0));
        vecs.push_back(mk(0, 1'b0, 6'd0,  4'h0, 5'h01, 1'b0));
        vecs.push_back(mk(0, 1'b0, 6'd1,  4'h0, 5'h02, 1'b0));
        foreach (vecs[k]) drive(vecs[k].inst, vecs[k].wr, vecs[k].addr, vecs[k].data,
                                vecs[k].exp_rsp, vecs[k].exp_wr_err);
        idle(2);

        for (int a = 0; a < 64; a++) m0[a] = 4'h0;
        m0[63] = 4'hC; m0[0] = 4'h1; m0[1] = 4'h2;
        for (int k = 0; k < 200; k++) begin
            logic       wr;
            logic [5:0] a;
            logic [3:0] d;
            wr = 1'($urandom_range(0, 1));
            a  = 6'($urandom_range(0, 63));
            d  = 4'($urandom_range(0, 15));
            if (wr) m0[a] = d;
            drive(0, wr, a, d, {1'b0, m0[a]}, 1'b0);
            if ($urandom_range(0, 3) == 0) idle(1);
        end

`ifdef MEM_CTRL_PROBE_EN
        drive(0, 1'b1, 6'd48, 4'h5, 5'h00, 1'b0);
        m0[48] = 4'h5;
        req_valid[0] = 1'b0;
        probe_addr[0] = 6'd48;
        probe_addr[1] = 6'd50;
        #1;
        chk("probe_data0_48", 32'(probe_data[0]), 32'(5));
        chk("probe_data1_50", 32'(probe_data[1]), 32'(0));
        chk("probe_no_rsp", 32'(rsp_valid[0]), 32'(0));
        @(negedge clk);
`endif

        // Response data must hold while rsp_valid is low.
        drive(0, 1'b0, 6'd63, 4'h0, {1'b0, m0[63]}, 1'b0);
        idle(3);
        chk("rdata_hold", 32'(rsp_rdata[0]), 32'(m0[63]));
        chk("rsp_valid_low", 32'(rsp_valid[0]), 32'(0));

        // Reset while a read response is on the outputs.
        m0[63] = 4'h9;
        drive(0, 1'b1, 6'd63, 4'h9, 5'h00, 1'b0);
        req_wr[0] = 1'b0;
        @(posedge clk);
        #1;
        chk("inflight_rsp_valid", 32'(rsp_valid[0]), 32'(1));
        chk("inflight_rdata", 32'(rsp_rdata[0]), 32'(9));
        rst_n = 1'b0;
        req_valid[0] = 1'b0;
        #1;
        check_reset_outputs("midop");
        exp_q0.delete();
        exp_q1.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // Reset again at sweep cycle 20; the sweep must restart from zero.
        repeat (20) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midsweep");
        @(negedge clk);
        rst_n = 1'b1;
        sweep_check("resweep");

        drive(0, 1'b0, 6'd63, 4'h0, 5'h00, 1'b0);
        drive(1, 1'b0, 6'd7,  4'h0, 5'h0A, 1'b0);
        idle(3);
        chk("drain_q0", 32'(exp_q0.size()), 32'(0));
        chk("drain_q1", 32'(exp_q1.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
